// File: rtl/vga_term_writer.sv
// Byte-stream front end for the VGA text display: interprets printable and control
// codes, tracks the cursor and drives single-cycle writes into the character memory.
module vga_term_writer #(
  parameter int COLS       = 210,
  parameter int ROWS       = 131,
  parameter int ADDR_WIDTH = $clog2(COLS * ROWS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_char,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic [ADDR_WIDTH-1:0] cursor_addr,
  output logic                  busy
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] COLS_A    = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_ROW} state_t;

  state_t                  state_q, state_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [ADDR_WIDTH-1:0]   rowBase_q, rowBase_d;
  logic [ADDR_WIDTH-1:0]   cursorAddr_q, cursorAddr_d;
  logic [ADDR_WIDTH-1:0]   clrAddr_q, clrAddr_d;
  logic [ADDR_WIDTH-1:0]   clrLast_q, clrLast_d;
  logic                    clrDone_q, clrDone_d;
  logic                    wrEn_q, wrEn_d;
  logic [ADDR_WIDTH-1:0]   wrAddr_q, wrAddr_d;
  logic [7:0]              wrData_q, wrData_d;

  logic                    lineAdv;
  logic                    blankFirst;
  logic [ROW_W-1:0]        nextRow;
  logic [ADDR_WIDTH-1:0]   nextBase;

  // Row base advances by COLS per row so the cursor address needs no multiplier.
  assign nextRow  = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
  assign nextBase = (row_q == LAST_ROW) ? '0 : rowBase_q + COLS_A;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    rowBase_d    = rowBase_q;
    cursorAddr_d = cursorAddr_q;
    clrAddr_d    = clrAddr_q;
    clrLast_d    = clrLast_q;
    clrDone_d    = clrDone_q;
    wrEn_d       = 1'b0;
    wrAddr_d     = wrAddr_q;
    wrData_d     = wrData_q;
    lineAdv      = 1'b0;
    blankFirst   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            wrEn_d   = 1'b1;
            wrAddr_d = cursorAddr_q;
            wrData_d = in_char;
            if (col_q != LAST_COL) begin
              col_d        = col_q + COL_W'(1);
              cursorAddr_d = cursorAddr_q + ONE_A;
            end else begin
              lineAdv = 1'b1;
            end
          end else if (in_char == CH_LF) begin
            lineAdv    = 1'b1;
            blankFirst = 1'b1;
          end else if (in_char == CH_CR) begin
            col_d        = '0;
            cursorAddr_d = rowBase_q;
          end else if (in_char == CH_BS) begin
            if (col_q != '0) begin
              col_d        = col_q - COL_W'(1);
              cursorAddr_d = cursorAddr_q - ONE_A;
              wrEn_d       = 1'b1;
              wrAddr_d     = cursorAddr_q - ONE_A;
              wrData_d     = BLANK;
            end
          end else if (in_char == CH_FF) begin
            state_d      = CLR_ALL;
            col_d        = '0;
            row_d        = '0;
            rowBase_d    = '0;
            cursorAddr_d = '0;
            wrEn_d       = 1'b1;
            wrAddr_d     = '0;
            wrData_d     = BLANK;
            clrAddr_d    = ONE_A;
            clrLast_d    = LAST_CELL;
            clrDone_d    = (COLS * ROWS == 1);
          end
        end
      end
      CLR_ALL, CLR_ROW: begin
        // The done flag buys one idle cycle after the final blank before accepting bytes.
        if (clrDone_q) begin
          state_d = IDLE;
        end else begin
          wrEn_d    = 1'b1;
          wrAddr_d  = clrAddr_q;
          wrData_d  = BLANK;
          clrDone_d = (clrAddr_q == clrLast_q);
          if (clrAddr_q != clrLast_q) clrAddr_d = clrAddr_q + ONE_A;
        end
      end
      default: state_d = IDLE;
    endcase

    if (lineAdv) begin
      state_d      = CLR_ROW;
      col_d        = '0;
      row_d        = nextRow;
      rowBase_d    = nextBase;
      cursorAddr_d = nextBase;
      clrAddr_d    = nextBase;
      clrLast_d    = nextBase + COLS_A - ONE_A;
      clrDone_d    = 1'b0;
      // LF has no character write, so its first blank can go out immediately.
      if (blankFirst) begin
        wrEn_d    = 1'b1;
        wrAddr_d  = nextBase;
        wrData_d  = BLANK;
        clrAddr_d = nextBase + ONE_A;
        clrDone_d = (COLS == 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLR_ALL;
      col_q        <= '0;
      row_q        <= '0;
      rowBase_q    <= '0;
      cursorAddr_q <= '0;
      clrAddr_q    <= '0;
      clrLast_q    <= LAST_CELL;
      clrDone_q    <= 1'b0;
      wrEn_q       <= 1'b0;
      wrAddr_q     <= '0;
      wrData_q     <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      rowBase_q    <= rowBase_d;
      cursorAddr_q <= cursorAddr_d;
      clrAddr_q    <= clrAddr_d;
      clrLast_q    <= clrLast_d;
      clrDone_q    <= clrDone_d;
      wrEn_q       <= wrEn_d;
      wrAddr_q     <= wrAddr_d;
      wrData_q     <= wrData_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = ~in_ready;
  assign wr_en       = wrEn_q;
  assign wr_addr     = wrAddr_q;
  assign wr_data     = wrData_q;
  assign cursor_addr = cursorAddr_q;

endmodule

// File: tb/tb_vga_term_writer.sv
// Directed bench for vga_term_writer on a 4x3 screen with hand-computed write sequences.
module tb_vga_term_writer;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int AW   = 4;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_char;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] cursor_addr;
  logic          busy;

  int assertCount = 0;
  int failCount   = 0;

  vga_term_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_addr(cursor_addr),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte for exactly one edge; returns in the cycle after acceptance.
  task automatic applyStimulus(input logic [7:0] ch);
    in_valid = 1'b1;
    in_char  = ch;
    stepCycle();
    in_valid = 1'b0;
    in_char  = 8'h00;
  endtask

  task automatic checkWrite(input string tag, input int addr, input int data, input logic rdy);
    checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'd1);
    checkOutput({tag, "_addr"}, 32'(wr_addr), 32'(addr));
    checkOutput({tag, "_data"}, 32'(wr_data), 32'(data));
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'(rdy));
    checkOutput({tag, "_busy"}, 32'(busy), 32'(!rdy));
  endtask

  task automatic checkNoWrite(input string tag, input int cur);
    checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    checkOutput({tag, "_cursor"}, 32'(cursor_addr), 32'(cur));
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Expects n ascending blank writes starting now, then in_ready back high.
  task automatic checkBlankRun(input string tag, input int startAddr, input int n);
    for (int i = 0; i < n; i++) begin
      checkWrite($sformatf("%s_%0d", tag, i), startAddr + i, 8'h20, 1'b0);
      stepCycle();
    end
    checkOutput({tag, "_done_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_done_wr_en"}, 32'(wr_en), 32'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    checkOutput({tag, "_addr"}, 32'(wr_addr), 32'd0);
    checkOutput({tag, "_data"}, 32'(wr_data), 32'd0);
    checkOutput({tag, "_cursor"}, 32'(cursor_addr), 32'd0);
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_char  = 8'h00;
    stepCycle();
    stepCycle();
    checkResetState("rst");

    // Cycle R: reset low; blanks appear in R+1..R+12.
    reset = 1'b0;
    stepCycle();
    checkBlankRun("pwrclr", 0, COLS * ROWS);
    checkOutput("pwrclr_cursor", 32'(cursor_addr), 32'd0);

    // Back-to-back "AB" with in_valid held high.
    in_valid = 1'b1;
    in_char  = 8'h41;
    stepCycle();
    checkWrite("A", 0, 8'h41, 1'b1);
    checkOutput("A_cursor", 32'(cursor_addr), 32'd1);
    in_char = 8'h42;
    stepCycle();
    checkWrite("B", 1, 8'h42, 1'b1);
    checkOutput("B_cursor", 32'(cursor_addr), 32'd2);
    in_valid = 1'b0;
    stepCycle();
    checkNoWrite("AB_idle", 2);

    // LF from row 0 blanks row 1 (addresses 4..7).
    applyStimulus(8'h0A);
    checkOutput("lf0_cursor", 32'(cursor_addr), 32'd4);
    checkBlankRun("lf0", 4, COLS);

    applyStimulus(8'h78);
    checkWrite("x", 4, 8'h78, 1'b1);
    applyStimulus(8'h79);
    checkWrite("y", 5, 8'h79, 1'b1);
    checkOutput("y_cursor", 32'(cursor_addr), 32'd6);

    applyStimulus(8'h08);
    checkWrite("bs", 5, 8'h20, 1'b1);
    checkOutput("bs_cursor", 32'(cursor_addr), 32'd5);

    applyStimulus(8'h78);
    checkWrite("x2", 5, 8'h78, 1'b1);
    applyStimulus(8'h0D);
    checkNoWrite("cr", 4);
    applyStimulus(8'h08);
    checkNoWrite("bs_col0", 4);
    applyStimulus(8'h07);
    checkNoWrite("bel", 4);

    // LF from row 1 blanks row 2 (addresses 8..11).
    applyStimulus(8'h0A);
    checkOutput("lf1_cursor", 32'(cursor_addr), 32'd8);
    checkBlankRun("lf1", 8, COLS);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h61 + 8'(i));
      checkWrite($sformatf("abc_%0d", i), 8 + i, 8'h61 + i, 1'b1);
    end
    checkOutput("abc_cursor", 32'(cursor_addr), 32'd11);

    // 'Z' at the last cell wraps to row 0 and blanks it.
    applyStimulus(8'h5A);
    checkWrite("Z", 11, 8'h5A, 1'b0);
    checkOutput("Z_cursor", 32'(cursor_addr), 32'd0);
    stepCycle();
    checkBlankRun("wrap", 0, COLS);
    checkOutput("wrap_cursor", 32'(cursor_addr), 32'd0);

    // FF, then reset after five blanks; the clear restarts from 0.
    applyStimulus(8'h0C);
    for (int i = 0; i < 5; i++) begin
      checkWrite($sformatf("ff_%0d", i), i, 8'h20, 1'b0);
      if (i < 4) stepCycle();
    end
    reset = 1'b1;
    stepCycle();
    checkResetState("midrst");
    reset = 1'b0;
    stepCycle();
    checkBlankRun("reclr", 0, COLS * ROWS);
    checkOutput("reclr_cursor", 32'(cursor_addr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
